// File: rtl/mc_pkg.sv
// mc_pkg: state, ALU operation and data-processing cmd encodings shared by the decoder.
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        MULWAIT  = 4'd10
    } state_t;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4, ALU_MOV = 3'd5, ALU_MUL = 3'd6;
    localparam logic [3:0] CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010, CMD_ORR = 4'b1100, CMD_MOV = 4'b1101;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: combinational ALU operation select and flag-write enables from the cmd/S bits.
module alu_dec import mc_pkg::*; #(
    parameter int ALUCTRL_W = 4
) (
    input  logic [4:0]           funct_i,
    input  logic                 exec_i,
    input  logic                 mul_i,
    output logic [ALUCTRL_W-1:0] alu_ctrl_o,
    output logic [1:0]           flag_w_o
);
    logic [3:0] cmd;
    logic [2:0] op_code, ctl;
    logic       cmp, arith;
    always_comb begin
        cmd = funct_i[4:1];
        case (cmd)
            CMD_SUB, CMD_CMP: op_code = ALU_SUB;
            CMD_AND:          op_code = ALU_AND;
            CMD_ORR:          op_code = ALU_ORR;
            CMD_EOR:          op_code = ALU_EOR;
            CMD_MOV:          op_code = ALU_MOV;
            default:          op_code = ALU_ADD;
        endcase
        cmp = cmd == CMD_CMP;
        arith = cmp || cmd == CMD_ADD || cmd == CMD_SUB;
        ctl = mul_i ? ALU_MUL : exec_i ? op_code : ALU_ADD;
        // CMP always updates all flags, even without the S bit
        flag_w_o = !(exec_i || mul_i) ? 2'b00 : cmp ? 2'b11 : {funct_i[0], funct_i[0] & arith};
        alu_ctrl_o = ALUCTRL_W'(ctl);
    end
endmodule

// File: rtl/mc_decoder.sv
// mc_decoder: multicycle ARM-subset control FSM with multiply latency counter.
module mc_decoder import mc_pkg::*; #(
    parameter int MUL_LAT   = 3,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           op,
    input  logic [5:0]           funct,
    input  logic [3:0]           rd,
    input  logic                 is_mul,
    input  logic                 mem_ready,
    output logic                 IRWrite,
    output logic                 nextPC,
    output logic                 regW,
    output logic                 memW,
    output logic                 PCS,
    output logic                 branch,
    output logic                 adrSrc,
    output logic [1:0]           flagW,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           resultSrc,
    output logic [1:0]           immSrc,
    output logic [1:0]           regSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           state
);
    state_t     state_d, state_q, s;
    logic [3:0] cnt_d, cnt_q;
    logic       mul_done, fd;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        mul_done = cnt_q == 4'(MUL_LAT - 1);
        cnt_d = '0;
        case (state_q)
            FETCH:             state_d = mem_ready ? DECODE : FETCH;
            DECODE:            state_d = op == 2'b01 ? MEMADR :
                                         op == 2'b10 ? BRANCH :
                                         op == 2'b00 && is_mul ? MULWAIT :
                                         op == 2'b00 && funct[5] ? EXECUTEI : EXECUTER;
            MEMADR:            state_d = funct[0] ? MEMRD : MEMWR;
            MEMRD:             state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:             state_d = mem_ready ? FETCH : MEMWR;
            EXECUTER, EXECUTEI: state_d = ALUWB;
            MULWAIT: begin
                state_d = mul_done ? ALUWB : MULWAIT;
                cnt_d = mul_done ? '0 : cnt_q + 4'd1;
            end
            default:           state_d = FETCH;
        endcase
    end
    // While reset is held the outputs already present the FETCH view
    always_comb begin
        s = reset ? FETCH : state_q;
        fd = s == FETCH || s == DECODE;
        IRWrite = s == FETCH && mem_ready && !reset;
        nextPC = IRWrite;
        regW = s == MEMWB || (s == ALUWB && funct[4:1] != CMD_CMP);
        memW = s == MEMWR;
        branch = s == BRANCH;
        PCS = branch || (regW && rd == 4'hF);
        adrSrc = s == MEMRD || s == MEMWR;
        ALUSrcA = fd ? 2'b01 : 2'b00;
        ALUSrcB = fd ? 2'b10 : (s == MEMADR || s == EXECUTEI || s == BRANCH) ? 2'b01 : 2'b00;
        resultSrc = fd ? 2'b10 : s == MEMWB ? 2'b01 : 2'b00;
        immSrc = op;
        regSrc = {op == 2'b01, op == 2'b10};
        state = s;
    end
    alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .funct_i   (funct[4:0]),
        .exec_i    (s == EXECUTER || s == EXECUTEI),
        .mul_i     (s == MULWAIT),
        .alu_ctrl_o(ALUControl),
        .flag_w_o  (flagW)
    );
endmodule

// File: tb/tb_mc_decoder.sv
// tb_mc_decoder: directed table, multi-cycle corner sequences and random stimulus vs a reference model.
module tb_mc_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, is_mul, mem_ready;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [1:0] irw, npc, rw, mw, pcs, br, adr;
    logic [1:0] fw[2], asa[2], asb[2], rs[2], ims[2], rgs[2];
    logic [3:0] aluc[2], st[2];

    mc_decoder #(.MUL_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .is_mul(is_mul),
        .mem_ready(mem_ready), .IRWrite(irw[0]), .nextPC(npc[0]), .regW(rw[0]), .memW(mw[0]),
        .PCS(pcs[0]), .branch(br[0]), .adrSrc(adr[0]), .flagW(fw[0]), .ALUSrcA(asa[0]),
        .ALUSrcB(asb[0]), .resultSrc(rs[0]), .immSrc(ims[0]), .regSrc(rgs[0]),
        .ALUControl(aluc[0]), .state(st[0])
    );
    mc_decoder #(.MUL_LAT(5)) dut5 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .is_mul(is_mul),
        .mem_ready(mem_ready), .IRWrite(irw[1]), .nextPC(npc[1]), .regW(rw[1]), .memW(mw[1]),
        .PCS(pcs[1]), .branch(br[1]), .adrSrc(adr[1]), .flagW(fw[1]), .ALUSrcA(asa[1]),
        .ALUSrcB(asb[1]), .resultSrc(rs[1]), .immSrc(ims[1]), .regSrc(rgs[1]),
        .ALUControl(aluc[1]), .state(st[1])
    );

    typedef struct packed {
        logic IRWrite, nextPC, regW, memW, PCS, branch, adrSrc;
        logic [1:0] flagW, ALUSrcA, ALUSrcB, resultSrc, immSrc, regSrc;
        logic [3:0] ALUControl, state;
    } out_t;

    typedef struct {
        logic rst; logic [1:0] op; logic [5:0] f; logic [3:0] rd; logic mul; logic mr;
        logic [3:0] st; logic irw, rw, mw, pcs; logic [2:0] alu; logic [1:0] fw;
    } vec_t;

    int checks = 0, errors = 0;
    int m_st[2], m_rem[2];
    vec_t tbl[$];
    logic t_rst, t_mul;
    logic [1:0] t_op;
    logic [5:0] t_f;
    logic [3:0] t_rd;

    // Reference: state numbering and output rules taken straight from the state table
    function automatic logic [3:0] alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'd0;
            4'b0010, 4'b1010: return 4'd1;
            4'b0000: return 4'd2;
            4'b1100: return 4'd3;
            4'b0001: return 4'd4;
            4'b1101: return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    function automatic out_t exp_out(input int stn);
        out_t e;
        int s;
        logic [3:0] cmd;
        logic cmp;
        s = reset ? 0 : stn;
        cmd = funct[4:1];
        cmp = cmd == 4'b1010;
        e = '0;
        e.state = 4'(s);
        e.IRWrite = s == 0 && mem_ready && !reset;
        e.nextPC = e.IRWrite;
        e.regW = s == 4 || (s == 8 && !cmp);
        e.memW = s == 5;
        e.branch = s == 9;
        e.adrSrc = s == 3 || s == 5;
        e.PCS = s == 9 || (e.regW && rd == 4'd15);
        if (s <= 1) begin
            e.ALUSrcA = 2'd1;
            e.ALUSrcB = 2'd2;
            e.resultSrc = 2'd2;
        end
        if (s == 2 || s == 7 || s == 9) e.ALUSrcB = 2'd1;
        if (s == 4) e.resultSrc = 2'd1;
        e.immSrc = op;
        e.regSrc = {op == 2'd1, op == 2'd2};
        if (s == 6 || s == 7) e.ALUControl = alu_code(cmd);
        if (s == 10) e.ALUControl = 4'd6;
        if (s == 6 || s == 7 || s == 10)
            e.flagW = cmp ? 2'b11 : {funct[0], funct[0] && (cmd == 4'b0100 || cmd == 4'b0010)};
        return e;
    endfunction

    function automatic void step_model(input int k);
        if (reset) begin
            m_st[k] = 0;
            m_rem[k] = 0;
            return;
        end
        case (m_st[k])
            0: if (mem_ready) m_st[k] = 1;
            1: begin
                if (op == 2'd1) m_st[k] = 2;
                else if (op == 2'd2) m_st[k] = 9;
                else if (op == 2'd0 && is_mul) begin
                    m_st[k] = 10;
                    m_rem[k] = k == 1 ? 5 : 3;
                end
                else if (op == 2'd0 && funct[5]) m_st[k] = 7;
                else m_st[k] = 6;
            end
            2: m_st[k] = funct[0] ? 3 : 5;
            3: if (mem_ready) m_st[k] = 4;
            5: if (mem_ready) m_st[k] = 0;
            6, 7: m_st[k] = 8;
            10: begin
                m_rem[k]--;
                if (m_rem[k] == 0) m_st[k] = 8;
            end
            default: m_st[k] = 0;
        endcase
    endfunction

    function automatic out_t got(input int k);
        return {irw[k], npc[k], rw[k], mw[k], pcs[k], br[k], adr[k], fw[k], asa[k], asb[k],
                rs[k], ims[k], rgs[k], aluc[k], st[k]};
    endfunction

    task automatic drive(input logic r, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] d, input logic m, input logic mr);
        reset = r; op = o; funct = f; rd = d; is_mul = m; mem_ready = mr;
    endtask

    task automatic sample();
        out_t e, g;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = exp_out(m_st[k]);
            g = got(k);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL model dut%0d @%0t: got %h required %h", k, $time, g, e);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 2; k++) step_model(k);
        #1;
    endtask

    task automatic cyc(input logic r, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] d, input logic m, input logic mr);
        drive(r, o, f, d, m, mr);
        sample();
        advance();
    endtask

    task automatic chk(input string nm, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, g, e);
        end
    endtask

    task automatic ins(input logic r, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] d, input logic m);
        t_rst = r; t_op = o; t_f = f; t_rd = d; t_mul = m;
    endtask

    task automatic r(input logic mr, input logic [3:0] s, input logic i, input logic w,
                     input logic m, input logic p, input logic [2:0] a, input logic [1:0] fl);
        tbl.push_back('{t_rst, t_op, t_f, t_rd, t_mul, mr, s, i, w, m, p, a, fl});
    endtask

    task automatic mul_count(input string nm);
        int n3, n5;
        n3 = 0;
        n5 = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 2'b00, 6'b000001, 4'd6, 1'b1, i == 0);
            sample();
            n3 += int'(st[0] == 4'd10);
            n5 += int'(st[1] == 4'd10);
            advance();
        end
        chk({nm, "_lat3"}, n3, 3);
        chk({nm, "_lat5"}, n5, 5);
    endtask

    initial begin
        m_st = '{0, 0};
        m_rem = '{0, 0};
        //     mr st irw rw mw pcs alu fw
        ins(1, 2'b00, 6'b000000, 4'd0, 0);  r(1, 0, 0, 0, 0, 0, 0, 0);
        ins(0, 2'b00, 6'b001000, 4'd1, 0);                       // ADD R1
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0);
        r(0, 6, 0, 0, 0, 0, 0, 0); r(0, 8, 0, 1, 0, 0, 0, 0);
        ins(0, 2'b01, 6'b011001, 4'd2, 0);                       // LDR
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0); r(0, 2, 0, 0, 0, 0, 0, 0);
        r(0, 3, 0, 0, 0, 0, 0, 0); r(0, 3, 0, 0, 0, 0, 0, 0); r(0, 3, 0, 0, 0, 0, 0, 0);
        r(1, 3, 0, 0, 0, 0, 0, 0); r(0, 4, 0, 1, 0, 0, 0, 0);
        ins(0, 2'b01, 6'b011000, 4'd3, 0);                       // STR
        r(0, 0, 0, 0, 0, 0, 0, 0); r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0);
        r(0, 2, 0, 0, 0, 0, 0, 0); r(0, 5, 0, 0, 1, 0, 0, 0); r(0, 5, 0, 0, 1, 0, 0, 0);
        r(1, 5, 0, 0, 1, 0, 0, 0); r(0, 0, 0, 0, 0, 0, 0, 0);
        ins(0, 2'b00, 6'b010101, 4'd0, 0);                       // CMPS
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0);
        r(0, 6, 0, 0, 0, 0, 1, 3); r(0, 8, 0, 0, 0, 0, 0, 0);
        ins(0, 2'b00, 6'b111010, 4'd15, 0);                      // MOV PC, #imm
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0);
        r(0, 7, 0, 0, 0, 0, 5, 0); r(0, 8, 0, 1, 0, 1, 0, 0);
        ins(0, 2'b00, 6'b100101, 4'd4, 0);                       // SUBS #imm
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0);
        r(0, 7, 0, 0, 0, 0, 1, 3); r(0, 8, 0, 1, 0, 0, 0, 0);
        ins(0, 2'b00, 6'b000001, 4'd5, 0);                       // ANDS
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0);
        r(0, 6, 0, 0, 0, 0, 2, 2); r(0, 8, 0, 1, 0, 0, 0, 0);
        ins(0, 2'b10, 6'b000000, 4'd0, 0);                       // B
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0); r(0, 9, 0, 0, 0, 1, 0, 0);
        ins(0, 2'b00, 6'b000001, 4'd6, 1);                       // MULS, latency 3
        r(1, 0, 1, 0, 0, 0, 0, 0); r(0, 1, 0, 0, 0, 0, 0, 0); r(0, 10, 0, 0, 0, 0, 6, 2);
        r(0, 10, 0, 0, 0, 0, 6, 2); r(0, 10, 0, 0, 0, 0, 6, 2); r(0, 8, 0, 1, 0, 0, 0, 0);
        r(0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].f, tbl[i].rd, tbl[i].mul, tbl[i].mr);
            sample();
            checks++;
            if ({st[0], irw[0], rw[0], mw[0], pcs[0], aluc[0][2:0], fw[0]} !==
                {tbl[i].st, tbl[i].irw, tbl[i].rw, tbl[i].mw, tbl[i].pcs, tbl[i].alu, tbl[i].fw}) begin
                errors++;
                $display("FAIL vec%0d: got st=%0d irw=%b rw=%b mw=%b pcs=%b alu=%0d fw=%b required st=%0d irw=%b rw=%b mw=%b pcs=%b alu=%0d fw=%b",
                         i, st[0], irw[0], rw[0], mw[0], pcs[0], aluc[0][2:0], fw[0],
                         tbl[i].st, tbl[i].irw, tbl[i].rw, tbl[i].mw, tbl[i].pcs, tbl[i].alu, tbl[i].fw);
            end
            advance();
        end

        cyc(1'b1, 2'b00, 6'b0, 4'd0, 1'b0, 1'b0);
        mul_count("mul");

        cyc(1'b1, 2'b00, 6'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 6'b000001, 4'd6, 1'b1, i == 0);
        drive(1'b1, 2'b00, 6'b000001, 4'd6, 1'b1, 1'b1);
        sample();
        advance();
        drive(1'b0, 2'b00, 6'b000001, 4'd6, 1'b1, 1'b0);
        sample();
        chk("mulrst_state", st[1], 0);
        advance();
        mul_count("mul_after_rst");

        cyc(1'b1, 2'b00, 6'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 6'b011000, 4'd3, 1'b0, i == 0);
        drive(1'b0, 2'b01, 6'b011000, 4'd3, 1'b0, 1'b0);
        sample();
        chk("memwr_memw", mw[0], 1);
        advance();
        drive(1'b1, 2'b01, 6'b011000, 4'd3, 1'b0, 1'b0);
        sample();
        chk("memwr_rst_memw", mw[0], 0);
        advance();
        drive(1'b0, 2'b01, 6'b011000, 4'd3, 1'b0, 1'b0);
        sample();
        chk("memwr_after_rst_state", st[0], 0);
        chk("memwr_after_rst_memw", mw[0], 0);
        advance();

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(31) == 0, 2'($urandom), 6'($urandom), 4'($urandom),
                $urandom_range(3) == 0, $urandom_range(2) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_decoder.md
MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 Parameter MUL_LAT, default 3, number of MULWAIT cycles for a multiply (legal 1..15).
REQ-002 Parameter ALUCTRL_W, default 4, width of ALUControl (legal ≥3; upper bits zero-filled).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 op  in  2  instruction bits 27:26 (00 data-proc, 01 memory, 10 branch).
REQ-006 funct  in  6  instruction bits 25:20 (I, cmd[3:0], S/L).
REQ-007 rd  in  4  destination register field.
REQ-008 is_mul  in  1  instruction is MUL (externally decoded bits 7:4=1001, op=00).
REQ-009 mem_ready  in  1  memory completes the current access this cycle.
REQ-010 Outputs, 1 bit each: IRWrite, nextPC, regW, memW, PCS, branch, adrSrc.
REQ-011 Outputs, 2 bits each: flagW, ALUSrcA, ALUSrcB, resultSrc, immSrc, regSrc.
REQ-012 ALUControl  out  ALUCTRL_W  ALU operation select.
REQ-013 state  out  4  current FSM state (debug).

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MULWAIT=10; codes 11-15 SHALL return to FETCH next cycle.
REQ-015 FETCH: hold while mem_ready=0; on mem_ready=1 assert IRWrite=1 and nextPC=1 that cycle only and go to DECODE.
REQ-016 DECODE SHALL go to MEMADR (op=01), BRANCH (op=10), MULWAIT (op=00, is_mul=1), EXECUTEI (op=00, funct[5]=1), else EXECUTER.
REQ-017 MEMADR SHALL go to MEMRD if funct[0]=1 (load), else MEMWR.
REQ-018 MEMRD: adrSrc=1; hold until mem_ready=1, then MEMWB. MEMWB: regW=1, resultSrc=01, then FETCH.
REQ-019 MEMWR: adrSrc=1, memW=1 every cycle until mem_ready=1, then FETCH; memW SHALL deassert the cycle after mem_ready is sampled high.
REQ-020 EXECUTER/EXECUTEI SHALL go to ALUWB; ALUWB: regW=1, resultSrc=00, then FETCH; for CMP (cmd=1010) ALUWB SHALL assert regW=0.
REQ-021 MULWAIT SHALL stay exactly MUL_LAT cycles (internal counter), then ALUWB; ALUControl=MUL during MULWAIT.
REQ-022 BRANCH: branch=1, ALUSrcA=0, ALUSrcB=01, then FETCH.
REQ-023 Datapath selects: FETCH/DECODE ALUSrcA=1, ALUSrcB=10, resultSrc=10; MEMADR/EXECUTEI ALUSrcB=01; EXECUTER ALUSrcB=00; adrSrc=0 outside MEMRD/MEMWR.
REQ-024 ALUControl in EXECUTER/EXECUTEI from cmd: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 0001 EOR=4, 1101 MOV=5, 1010 CMP=1, MUL=6, unlisted=0; all other states 0 (ADD).
REQ-025 flagW[1] (NZ) = funct[0] in EXECUTE/MULWAIT; flagW[0] (CV) = funct[0] AND cmd∈{ADD,SUB,CMP}; CMP SHALL force flagW=11; 00 elsewhere.
REQ-026 immSrc = op (combinational); regSrc[0]=op==10, regSrc[1]=op==01.
REQ-027 PCS = branch state OR (regW asserted AND rd=1111).
REQ-028 Conditional-execution gating of regW/memW/PCS SHALL be external.

Reset
REQ-029 reset=1 at a rising edge SHALL set state=FETCH and MUL counter=0, overriding any transition, including mid-MEMWR and mid-MULWAIT.
REQ-030 While reset=1, IRWrite, nextPC, regW, memW, branch, PCS SHALL be 0 regardless of mem_ready; other outputs SHALL take FETCH values.

Structure
REQ-031 State codes, ALUControl codes and cmd encodings SHALL live in shared package mc_pkg.
REQ-032 ALUControl/flagW decode SHALL be sub-module alu_dec (combinational); FSM and counter SHALL be in mc_decoder.

Verification
REQ-033 ADD R1 (op=00,funct=001000,rd=1), mem_ready=1 -> FETCH,DECODE,EXECUTER,ALUWB,FETCH; ALUControl=0 in EXECUTER; regW=1 only in ALUWB.
REQ-034 LDR (op=01,funct=011001), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB regW=1, resultSrc=01.
REQ-035 STR with mem_ready low 2 cycles -> memW=1 for 3 cycles, then 0, state FETCH.
REQ-036 MUL (is_mul=1), MUL_LAT=3 and MUL_LAT=5 -> MULWAIT exactly 3/5 cycles, ALUControl=6.
REQ-037 CMPS (funct=010101) -> flagW=11, regW=0 in ALUWB; MOV to rd=15 -> PCS=1 in ALUWB.
REQ-038 reset=1 during MEMWR with mem_ready=0 -> next cycle state=FETCH, memW=0.
